// File: rtl/temp_calc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : temp_calc_scheduler
//  Purpose  : Time-multiplexes the single temperature calculator across NCH
//             ADC sensor channels. Each sweep requests a sample per channel,
//             loads the calculator operands, waits for the result to settle
//             and publishes it with a one-cycle strobe. Sweeps repeat every
//             PERIOD idle cycles while start_en is held high.
//  Revision : 1.0  initial release
// ============================================================================
module temp_calc_scheduler #(
    parameter int NCH         = 4,
    parameter int PERIOD      = 1000,
    parameter int CALC_LAT    = 1,
    parameter int ADC_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_en,
    input  logic [31:0]               tc_base_in,
    input  logic [7:0]                tc_ref_in,
    output logic                      adc_req,
    output logic [$clog2(NCH)-1:0]    adc_sel,
    input  logic                      adc_ack,
    input  logic [15:0]               adc_data_in,
    output logic [31:0]               calc_base,
    output logic [7:0]                calc_ref,
    output logic [15:0]               calc_adc,
    input  logic [31:0]               calc_tempc,
    output logic                      temp_valid,
    output logic [$clog2(NCH)-1:0]    temp_ch,
    output logic [31:0]               temp_value,
    output logic                      sweep_done,
    output logic [NCH-1:0]            timeout_err,
    output logic                      busy
);

    localparam int CHW     = $clog2(NCH);
    localparam int MAX_A   = (PERIOD > CALC_LAT) ? PERIOD : CALC_LAT;
    localparam int MAX_CNT = (MAX_A > ADC_TIMEOUT) ? MAX_A : ADC_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0]  TO_LAST     = CW'(ADC_TIMEOUT - 1);
    localparam logic [CW-1:0]  CALC_LAST   = CW'(CALC_LAT - 1);
    localparam logic [CW-1:0]  PERIOD_LAST = CW'(PERIOD - 1);
    localparam logic [CHW-1:0] LAST_CH     = CHW'(NCH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_CALC  = 3'd2,
        S_STORE = 3'd3,
        S_NEXT  = 3'd4,
        S_WAIT  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CHW-1:0]  ch;
    logic            last_ch;
    logic            enter_sweep;
    logic            req_timeout;

    assign last_ch = (ch == LAST_CH);

    // Combinational handshake outputs decode straight from the state register
    // so they fall the instant the asynchronous reset clears the FSM.
    assign adc_req = (state == S_REQ);
    assign adc_sel = ch;
    assign busy    = (state != S_IDLE);

    // A sweep begins from IDLE or at the end of the inter-sweep wait.
    assign enter_sweep = start_en &&
                         ((state == S_IDLE) ||
                          ((state == S_WAIT) && (cnt == '0)));

    // Ack wins over timeout when both land on the same edge.
    assign req_timeout = (state == S_REQ) && !adc_ack && (cnt == TO_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_en) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (adc_ack)            state_nxt = S_CALC;
                else if (cnt == TO_LAST) state_nxt = S_NEXT;
            end
            S_CALC: begin
                if (cnt == CALC_LAST) state_nxt = S_STORE;
            end
            S_STORE: begin
                state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (!start_en)    state_nxt = S_IDLE;
                else if (last_ch) state_nxt = S_WAIT;
                else              state_nxt = S_REQ;
            end
            S_WAIT: begin
                if (!start_en)       state_nxt = S_IDLE;
                else if (cnt == '0)  state_nxt = S_REQ;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Shared cycle counter: counts up for ADC timeout and calc settle,
    // counts down through the inter-sweep period, restarts on every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= (state_nxt == S_WAIT) ? PERIOD_LAST : '0;
        end else begin
            case (state)
                S_REQ, S_CALC: cnt <= cnt + 1'b1;
                S_WAIT:        cnt <= cnt - 1'b1;
                default:       cnt <= '0;
            endcase
        end
    end

    // Channel index: restarts at each sweep, advances only out of NEXT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch <= '0;
        end else if (enter_sweep) begin
            ch <= '0;
        end else if ((state == S_NEXT) && start_en) begin
            ch <= last_ch ? '0 : ch + 1'b1;
        end
    end

    // Calculator operands: base/ref frozen for the whole sweep, ADC sample
    // loaded on the accepting edge of the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calc_base <= '0;
            calc_ref  <= '0;
            calc_adc  <= '0;
        end else begin
            if (enter_sweep) begin
                calc_base <= tc_base_in;
                calc_ref  <= tc_ref_in;
            end
            if ((state == S_REQ) && adc_ack) begin
                calc_adc <= adc_data_in;
            end
        end
    end

    // Result capture and the one-cycle strobes that follow STORE / last NEXT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temp_value <= '0;
            temp_ch    <= '0;
            temp_valid <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            temp_valid <= (state == S_STORE);
            sweep_done <= (state == S_NEXT) && last_ch;
            if (state == S_STORE) begin
                temp_value <= calc_tempc;
                temp_ch    <= ch;
            end
        end
    end

    // Sticky per-channel timeout flags; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= '0;
        end else if (req_timeout) begin
            timeout_err[ch] <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_temp_calc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_temp_calc_scheduler
//  Purpose  : Directed bench for temp_calc_scheduler with a behavioural ADC
//             responder and a simple calculator model (base + ref * adc).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_temp_calc_scheduler;

    localparam int NCH         = 4;
    localparam int PERIOD      = 20;
    localparam int CALC_LAT    = 1;
    localparam int ADC_TIMEOUT = 8;

    logic        clk;
    logic        rst_n;
    logic        start_en;
    logic [31:0] tc_base_in;
    logic [7:0]  tc_ref_in;
    logic        adc_req;
    logic [1:0]  adc_sel;
    logic        adc_ack;
    logic [15:0] adc_data_in;
    logic [31:0] calc_base;
    logic [7:0]  calc_ref;
    logic [15:0] calc_adc;
    logic [31:0] calc_tempc;
    logic        temp_valid;
    logic [1:0]  temp_ch;
    logic [31:0] temp_value;
    logic        sweep_done;
    logic [3:0]  timeout_err;
    logic        busy;

    temp_calc_scheduler #(
        .NCH(NCH), .PERIOD(PERIOD), .CALC_LAT(CALC_LAT), .ADC_TIMEOUT(ADC_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_en(start_en),
        .tc_base_in(tc_base_in), .tc_ref_in(tc_ref_in),
        .adc_req(adc_req), .adc_sel(adc_sel), .adc_ack(adc_ack),
        .adc_data_in(adc_data_in),
        .calc_base(calc_base), .calc_ref(calc_ref), .calc_adc(calc_adc),
        .calc_tempc(calc_tempc),
        .temp_valid(temp_valid), .temp_ch(temp_ch), .temp_value(temp_value),
        .sweep_done(sweep_done), .timeout_err(timeout_err), .busy(busy)
    );

    // Calculator model.
    assign calc_tempc = calc_base + ({24'h0, calc_ref} * {16'h0, calc_adc});

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ADC responder configuration.
    int          ack_delay = 2;
    logic [3:0]  noack     = 4'b0000;
    logic [15:0] adc_mem [4];

    // ADC responder: acks ack_delay cycles into a request.
    initial begin
        int req_cycles;
        req_cycles  = 0;
        adc_ack     = 1'b0;
        adc_data_in = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (adc_req) begin
                req_cycles++;
                if (req_cycles == ack_delay && !noack[adc_sel]) begin
                    adc_ack     = 1'b1;
                    adc_data_in = adc_mem[adc_sel];
                end else begin
                    adc_ack     = 1'b0;
                end
            end else begin
                req_cycles = 0;
                adc_ack    = 1'b0;
            end
        end
    end

    // Output monitor.
    logic [31:0] q_val [$];
    logic [1:0]  q_ch  [$];
    int          sd_cnt   = 0;
    int          req2_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (temp_valid) begin
                q_val.push_back(temp_value);
                q_ch.push_back(temp_ch);
            end
            if (sweep_done) sd_cnt++;
            if (adc_req && adc_sel == 2'd2) req2_cnt++;
        end
    end

    task automatic wait_sweep_done(input string tag, input int budget);
        int start;
        int n;
        start = sd_cnt;
        n = 0;
        while (sd_cnt == start && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (sd_cnt == start) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_req(input string tag, input logic [1:0] c, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(adc_req && adc_sel == c) && n < budget);
        if (!(adc_req && adc_sel == c)) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        adc_mem[0] = 16'h0010;
        adc_mem[1] = 16'h0020;
        adc_mem[2] = 16'h0030;
        adc_mem[3] = 16'h0040;
        rst_n      = 1'b1;
        start_en   = 1'b0;
        tc_base_in = 32'd25;
        tc_ref_in  = 8'd1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",        {31'h0, busy},        32'd0);
        chk("rst_adc_req",     {31'h0, adc_req},     32'd0);
        chk("rst_temp_valid",  {31'h0, temp_valid},  32'd0);
        chk("rst_timeout_err", {28'h0, timeout_err}, 32'd0);
        chk("rst_calc_base",   calc_base,            32'd0);
        chk("rst_temp_value",  temp_value,           32'd0);
        rst_n = 1'b1;

        // Sweep 1: all channels ack after 2 cycles.
        @(negedge clk); #1;
        start_en = 1'b1;
        wait_sweep_done("sweep1", 500);
        chk("s1_count", q_val.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_val.size()) begin
                chk("s1_ch", {30'h0, q_ch[i]}, i);
            end
        end
        if (q_val.size() == 4) begin
            chk("s1_val0", q_val[0], 32'd41);
            chk("s1_val1", q_val[1], 32'd57);
            chk("s1_val2", q_val[2], 32'd73);
            chk("s1_val3", q_val[3], 32'd89);
        end
        chk("s1_calc_base", calc_base, 32'd25);
        chk("s1_calc_ref",  {24'h0, calc_ref}, 32'd1);
        chk("s1_no_timeout", {28'h0, timeout_err}, 32'd0);

        // Gap between sweep_done and next request equals PERIOD.
        n = 0;
        while (!adc_req && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("period_gap", n, PERIOD);

        // Sweep 2: ch2 silent, base changed mid-sweep.
        q_val.delete();
        q_ch.delete();
        req2_cnt   = 0;
        noack      = 4'b0100;
        tc_base_in = 32'd30;
        wait_sweep_done("sweep2", 500);
        chk("s2_count", q_val.size(), 32'd3);
        if (q_val.size() == 3) begin
            chk("s2_ch0",  {30'h0, q_ch[0]}, 32'd0);
            chk("s2_ch1",  {30'h0, q_ch[1]}, 32'd1);
            chk("s2_ch3",  {30'h0, q_ch[2]}, 32'd3);
            chk("s2_val3", q_val[2], 32'd89);
        end
        chk("s2_req2_cycles", req2_cnt, ADC_TIMEOUT);
        chk("s2_timeout_err", {28'h0, timeout_err}, 32'h4);
        chk("s2_base_held",   calc_base, 32'd25);

        // Sweep 3: ack on the timeout terminal cycle; start_en drops in ch1 CALC.
        noack     = 4'b0000;
        ack_delay = ADC_TIMEOUT;
        wait_req("s3_start", 2'd0, 200);
        chk("s3_base_new", calc_base, 32'd30);
        q_val.delete();
        q_ch.delete();
        n = sd_cnt;
        wait_req("s3_ch1", 2'd1, 200);
        begin
            int k;
            k = 0;
            while (adc_req && k < 50) begin
                @(negedge clk); #1;
                k++;
            end
        end
        start_en = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("s3_count", q_val.size(), 32'd2);
        if (q_val.size() == 2) begin
            chk("s3_val0", q_val[0], 32'd46);
            chk("s3_ch1",  {30'h0, q_ch[1]}, 32'd1);
            chk("s3_val1", q_val[1], 32'd62);
        end
        chk("s3_busy_idle",    {31'h0, busy}, 32'd0);
        chk("s3_no_sweepdone", sd_cnt, n);
        chk("s3_coincide_err", {28'h0, timeout_err}, 32'h4);

        // Reset in the middle of a request.
        ack_delay = 2;
        noack     = 4'b1111;
        start_en  = 1'b1;
        wait_req("s4_req", 2'd0, 50);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_adc_req",    {31'h0, adc_req},     32'd0);
        chk("arst_busy",       {31'h0, busy},        32'd0);
        chk("arst_timeout",    {28'h0, timeout_err}, 32'd0);
        chk("arst_calc_base",  calc_base,            32'd0);
        chk("arst_temp_value", temp_value,           32'd0);
        start_en = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("post_rst_idle", {31'h0, busy | adc_req}, 32'd0);
        start_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_start", {31'h0, busy}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute safety net.
    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
